// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, used by the fetch unit and the decoder.
package fetch_pkg;

  // Native address and instruction width of the core.
  localparam int XLEN = 32;

  // Canonical no-op (addi x0, x0, 0). The decoder substitutes it for a dropped slot.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One decoded-side buffer entry: an instruction word paired with its fetch PC.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misal;
  } fetch_entry_t;

  // Width of an occupancy counter that must hold values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/clear and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
// Clear has priority over push and pop and empties the FIFO on the next edge.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Pointer and occupancy bookkeeping; clear and reset both empty the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage array; no reset needed since count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

`ifndef SYNTHESIS
  // Protocol checks: the owner must never overflow or underflow the FIFO.
  always_ff @(posedge clk) begin
    if (rst_n && !clear_i) begin
      assert (!(push_i && !pop_i && count_q == CW'(DEPTH)))
        else $error("sync_fifo: push into full FIFO");
      assert (!(pop_i && count_q == '0))
        else $error("sync_fifo: pop from empty FIFO");
    end
  end
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts PCs, issues word reads to instruction memory,
// pairs each returned word with its PC and buffers it for the decoder.
//
// Handshakes (all sampled on posedge clk):
//   PC side     : a PC is consumed when pc_valid & pc_ready; pc_ready == imem_req & imem_gnt.
//   Memory side : a request is accepted when imem_req & imem_gnt; responses arrive in
//                 order on imem_rvalid at least one cycle after their grant.
//   Decode side : an entry is consumed when instr_valid & instr_ready; instr_valid never
//                 depends on instr_ready, and the entry holds until consumed or flushed.
//
// Credit scheme: buffered entries plus every outstanding request (including ones whose
// data will be dropped after a flush) may never exceed DEPTH, so every returning word
// always has a buffer slot waiting for it.
module instr_fetch_unit #(
  parameter int XLEN  = fetch_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_misal
);

  import fetch_pkg::*;

  localparam int CW = cnt_width(DEPTH);
  localparam int IW = XLEN + 1;      // in-flight entry: {pc, misal}
  localparam int BW = 2 * XLEN + 1;  // buffer entry:    {pc, instr, misal}
  localparam logic [CW:0] SLOTS = (CW + 1)'(DEPTH);

  // Outstanding = requests granted but not yet answered (kept or to-be-dropped).
  logic [CW-1:0] outstanding_q, outstanding_d;
  // Responses still owed by memory for requests that were flushed.
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] buf_count;
  logic [CW-1:0] infl_count;
  logic [CW:0]   used_slots;
  logic          has_credit;
  logic          grant;
  logic          drop_pending;
  logic          resp_keep;
  logic          buf_pop;

  logic [IW-1:0] infl_wdata, infl_rdata;
  logic [BW-1:0] buf_wdata, buf_rdata;
  logic [XLEN-1:0] infl_pc;
  logic            infl_misal;

  // Request issue: only with a free slot, never during flush or reset.
  always_comb begin
    used_slots = {1'b0, buf_count} + {1'b0, outstanding_q};
    has_credit = used_slots < SLOTS;
    imem_req   = rst_n & pc_valid & ~flush & has_credit;
    grant      = imem_req & imem_gnt;
  end

  assign pc_ready  = grant;
  assign imem_addr = {pc_in[XLEN-1:2], 2'b00};

  // A response is kept only when no flushed request is still owed and no flush is
  // active this cycle; older dropped responses always come back first.
  always_comb begin
    drop_pending = (drop_cnt_q != '0);
    resp_keep    = imem_rvalid & ~drop_pending & ~flush;
    buf_pop      = instr_valid & instr_ready;
  end

  // Outstanding and drop bookkeeping; a flush converts every live request into a drop,
  // except one answered in the flush cycle itself, which is discarded immediately.
  always_comb begin
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    drop_cnt_d    = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = outstanding_q - CW'(imem_rvalid);
    end else if (imem_rvalid && drop_pending) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // PCs of live requests, in issue order.
  assign infl_wdata = {pc_in, (pc_in[1:0] != 2'b00)};

  sync_fifo #(
    .WIDTH (IW),
    .DEPTH (DEPTH)
  ) u_inflight (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .push_i  (grant),
    .wdata_i (infl_wdata),
    .pop_i   (resp_keep),
    .rdata_o (infl_rdata),
    .count_o (infl_count)
  );

  assign infl_pc    = infl_rdata[IW-1:1];
  assign infl_misal = infl_rdata[0];

  // Output buffer presented to the decoder.
  assign buf_wdata = {infl_pc, imem_rdata, infl_misal};

  sync_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_outbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (flush),
    .push_i  (resp_keep),
    .wdata_i (buf_wdata),
    .pop_i   (buf_pop),
    .rdata_o (buf_rdata),
    .count_o (buf_count)
  );

  assign instr_valid = (buf_count != '0);
  assign instr_pc    = buf_rdata[BW-1:XLEN+1];
  assign instr_out   = buf_rdata[XLEN:1];
  assign instr_misal = buf_rdata[0];

`ifndef SYNTHESIS
  // Memory must never answer a request that was never granted; the in-flight queue
  // must always account for exactly the non-dropped outstanding requests.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rvalid && outstanding_q == '0))
        else $error("instr_fetch_unit: imem_rvalid with nothing outstanding");
      assert (outstanding_q == infl_count + drop_cnt_q)
        else $error("instr_fetch_unit: outstanding bookkeeping out of step");
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand-written
// flush sequences, then randomized traffic against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_misal;

  int tests_run    = 0;
  int tests_failed = 0;

  instr_fetch_unit #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_misal (instr_misal)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table type ----------------
  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        fl;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_misal;
  } vec_t;

  vec_t vq[$];

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] pc;
    logic        misal;
    logic        dropped;
  } mreq_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } mresp_t;

  logic [64:0] exp_q[$];   // {pc, instr, misal} in decoder order
  mreq_t       m_infl[$];  // every granted, unanswered request
  mresp_t      mem_q[$];   // memory-side pending responses

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic fl,
                       input logic gnt, input logic rv, input logic [31:0] rd,
                       input logic rdy);
    pc_valid    = pv;
    pc_in       = pc;
    flush       = fl;
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = rd;
    instr_ready = rdy;
    #1;
  endtask

  task automatic check_out(input string tag, input logic e_req, input logic e_valid,
                           input logic [31:0] e_instr, input logic [31:0] e_pc,
                           input logic e_misal);
    logic [31:0] e_addr;
    e_addr = {pc_in[31:2], 2'b00};
    chk($sformatf("%s.imem_req", tag), 32'(imem_req), 32'(e_req));
    chk($sformatf("%s.pc_ready", tag), 32'(pc_ready), 32'(e_req & imem_gnt));
    chk($sformatf("%s.instr_valid", tag), 32'(instr_valid), 32'(e_valid));
    if (e_req) chk($sformatf("%s.imem_addr", tag), imem_addr, e_addr);
    if (e_valid) begin
      chk($sformatf("%s.instr_out", tag), instr_out, e_instr);
      chk($sformatf("%s.instr_pc", tag), instr_pc, e_pc);
      chk($sformatf("%s.instr_misal", tag), 32'(instr_misal), 32'(e_misal));
    end
  endtask

  task automatic step(input string tag, input logic pv, input logic [31:0] pc,
                      input logic fl, input logic gnt, input logic rv,
                      input logic [31:0] rd, input logic rdy, input logic e_req,
                      input logic e_valid, input logic [31:0] e_instr,
                      input logic [31:0] e_pc, input logic e_misal);
    drive(pv, pc, fl, gnt, rv, rd, rdy);
    check_out(tag, e_req, e_valid, e_instr, e_pc, e_misal);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        r_rst, pv, fl, gnt, rdy, rv, e_req, e_valid;
    logic [31:0] rd, cur_pc;
    logic [64:0] head;
    mreq_t       r;
    mresp_t      m;

    rst_n = 1'b0;
    drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Reset held for two edges with pc_valid high: no request, no output.
    chk("reset0.imem_req", 32'(imem_req), 32'd0);
    chk("reset0.pc_ready", 32'(pc_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("reset1.imem_req", 32'(imem_req), 32'd0);
    chk("reset1.pc_ready", 32'(pc_ready), 32'd0);
    chk("reset1.instr_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: 1-cycle stream, back-pressure with DEPTH=2, misaligned PC.
    //              pv  pc      fl  gnt rv  rd          rdy | req valid instr   pc     misal
    vq.push_back('{1, 32'h00, 0, 1, 0, 32'h0,      1,   1, 0, 32'h0,    32'h0,  0});
    vq.push_back('{1, 32'h04, 0, 1, 1, 32'hA,      1,   1, 0, 32'h0,    32'h0,  0});
    vq.push_back('{1, 32'h08, 0, 1, 1, 32'hB,      1,   0, 1, 32'hA,    32'h0,  0});
    vq.push_back('{1, 32'h08, 0, 1, 0, 32'h0,      1,   1, 1, 32'hB,    32'h4,  0});
    vq.push_back('{0, 32'h00, 0, 0, 1, 32'hC,      1,   0, 0, 32'h0,    32'h0,  0});
    vq.push_back('{0, 32'h00, 0, 0, 0, 32'h0,      1,   0, 1, 32'hC,    32'h8,  0});
    vq.push_back('{0, 32'h00, 0, 0, 0, 32'h0,      1,   0, 0, 32'h0,    32'h0,  0});
    vq.push_back('{1, 32'h40, 0, 1, 0, 32'h0,      0,   1, 0, 32'h0,    32'h0,  0});
    vq.push_back('{1, 32'h44, 0, 1, 1, 32'h1040,   0,   1, 0, 32'h0,    32'h0,  0});
    vq.push_back('{1, 32'h48, 0, 1, 1, 32'h1044,   0,   0, 1, 32'h1040, 32'h40, 0});
    vq.push_back('{1, 32'h48, 0, 1, 0, 32'h0,      0,   0, 1, 32'h1040, 32'h40, 0});
    vq.push_back('{1, 32'h48, 0, 1, 0, 32'h0,      1,   0, 1, 32'h1040, 32'h40, 0});
    vq.push_back('{1, 32'h48, 0, 1, 0, 32'h0,      1,   1, 1, 32'h1044, 32'h44, 0});
    vq.push_back('{0, 32'h00, 0, 0, 1, 32'h1048,   1,   0, 0, 32'h0,    32'h0,  0});
    vq.push_back('{0, 32'h00, 0, 0, 0, 32'h0,      1,   0, 1, 32'h1048, 32'h48, 0});
    vq.push_back('{0, 32'h00, 0, 0, 0, 32'h0,      1,   0, 0, 32'h0,    32'h0,  0});
    vq.push_back('{1, 32'h22, 0, 1, 0, 32'h0,      1,   1, 0, 32'h0,    32'h0,  0});
    vq.push_back('{0, 32'h00, 0, 0, 1, 32'hDEAD,   1,   0, 0, 32'h0,    32'h0,  0});
    vq.push_back('{0, 32'h00, 0, 0, 0, 32'h0,      1,   0, 1, 32'hDEAD, 32'h22, 1});
    vq.push_back('{0, 32'h00, 0, 0, 0, 32'h0,      1,   0, 0, 32'h0,    32'h0,  0});

    for (int i = 0; i < vq.size(); i++) begin
      step($sformatf("vec%0d", i), vq[i].pv, vq[i].pc, vq[i].fl, vq[i].gnt, vq[i].rv,
           vq[i].rd, vq[i].rdy, vq[i].e_req, vq[i].e_valid, vq[i].e_instr,
           vq[i].e_pc, vq[i].e_misal);
    end

    // Flush with two outstanding, data 3 cycles late; only 0x100 surfaces.
    step("fl2.h0", 1, 32'h10,  0, 1, 0, 32'h0,        1, 1, 0, 0, 0, 0);
    step("fl2.h1", 1, 32'h14,  0, 1, 0, 32'h0,        1, 1, 0, 0, 0, 0);
    step("fl2.h2", 0, 32'h18,  1, 1, 0, 32'h0,        1, 0, 0, 0, 0, 0);
    chk("fl2.drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    step("fl2.h3", 1, 32'h100, 0, 1, 1, 32'hBAD0,     1, 0, 0, 0, 0, 0);
    step("fl2.h4", 1, 32'h100, 0, 1, 1, 32'hBAD4,     1, 1, 0, 0, 0, 0);
    step("fl2.h5", 0, 32'h0,   0, 0, 1, 32'h0100_0000, 1, 0, 0, 0, 0, 0);
    step("fl2.h6", 0, 32'h0,   0, 0, 0, 32'h0,        1, 0, 1, 32'h0100_0000, 32'h100, 0);
    step("fl2.h7", 0, 32'h0,   0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0);

    // Flush in the cycle the last response returns while the buffer holds an entry.
    step("flr.f0", 1, 32'h200, 0, 1, 0, 32'h0,    0, 1, 0, 0, 0, 0);
    step("flr.f1", 1, 32'h204, 0, 1, 1, 32'h2200, 0, 1, 0, 0, 0, 0);
    step("flr.f2", 1, 32'h208, 1, 1, 1, 32'h2204, 0, 0, 1, 32'h2200, 32'h200, 0);
    chk("flr.drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
    step("flr.f3", 0, 32'h0,   0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 0);
    step("flr.f4", 1, 32'h300, 0, 1, 0, 32'h0,    1, 1, 0, 0, 0, 0);
    step("flr.f5", 0, 32'h0,   0, 0, 1, 32'h3300, 1, 0, 0, 0, 0, 0);
    step("flr.f6", 0, 32'h0,   0, 0, 0, 32'h0,    1, 0, 1, 32'h3300, 32'h300, 0);
    step("flr.f7", 0, 32'h0,   0, 0, 0, 32'h0,    1, 0, 0, 0, 0, 0);

    // Back-to-back flushes: drop count accumulates, then drains to zero.
    step("fla.g0", 1, 32'h400, 0, 1, 0, 32'h0,     1, 1, 0, 0, 0, 0);
    step("fla.g1", 1, 32'h404, 0, 1, 0, 32'h0,     1, 1, 0, 0, 0, 0);
    step("fla.g2", 0, 32'h0,   1, 0, 0, 32'h0,     1, 0, 0, 0, 0, 0);
    step("fla.g3", 1, 32'h500, 1, 1, 1, 32'hDEAD0, 1, 0, 0, 0, 0, 0);
    chk("fla.drop_cnt1", 32'(dut.drop_cnt_q), 32'd1);
    step("fla.g4", 1, 32'h500, 0, 1, 1, 32'hDEAD4, 1, 1, 0, 0, 0, 0);
    chk("fla.drop_cnt0", 32'(dut.drop_cnt_q), 32'd0);
    step("fla.g5", 0, 32'h0,   0, 0, 1, 32'h5500,  1, 0, 0, 0, 0, 0);
    step("fla.g6", 0, 32'h0,   0, 0, 0, 32'h0,     1, 0, 1, 32'h5500, 32'h500, 0);
    step("fla.g7", 0, 32'h0,   0, 0, 0, 32'h0,     1, 0, 0, 0, 0, 0);

    // Clean reset so DUT and model start the random phase from the same empty state.
    rst_n = 1'b0;
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    cur_pc = 32'h1000;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      r_rst = ($urandom_range(0, 249) != 0);
      pv    = ($urandom_range(0, 3) != 0);
      fl    = ($urandom_range(0, 15) == 0);
      gnt   = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 2) != 0);
      rv    = 1'b0;
      rd    = $urandom;
      if (mem_q.size() != 0) begin
        if (mem_q[0].due <= cyc && $urandom_range(0, 3) != 0) begin
          rv = 1'b1;
          rd = mem_q[0].data;
        end
      end
      rst_n = r_rst;
      drive(pv, cur_pc, fl, gnt, rv, rd, rdy);

      e_req   = r_rst && pv && !fl && (exp_q.size() + m_infl.size() < DEPTH);
      e_valid = (exp_q.size() != 0);
      head    = e_valid ? exp_q[0] : 65'd0;
      check_out("rnd", e_req, e_valid, head[32:1], head[64:33], head[0]);

      if (!r_rst) begin
        exp_q.delete();
        m_infl.delete();
        mem_q.delete();
      end else begin
        if (e_valid && rdy) void'(exp_q.pop_front());
        if (rv) begin
          r = m_infl.pop_front();
          m = mem_q.pop_front();
          if (!r.dropped && !fl) exp_q.push_back({r.pc, rd, r.misal});
        end
        if (fl) begin
          exp_q.delete();
          foreach (m_infl[i]) m_infl[i].dropped = 1'b1;
        end
        if (e_req && gnt) begin
          m_infl.push_back('{cur_pc, (cur_pc[1:0] != 2'b00), 1'b0});
          mem_q.push_back('{cyc + $urandom_range(1, 4), $urandom});
        end
      end

      if (fl || !r_rst) begin
        if ($urandom_range(0, 7) == 0) cur_pc = $urandom & 32'h0000_FFFF;
        else                           cur_pc = $urandom & 32'h0000_FFFC;
      end else if (e_req && gnt) begin
        cur_pc = cur_pc + 32'd4;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
